// File: rtl/lint_w2n_pkg.sv
// Shared types and helpers for the wide-to-narrow LINT splitter.
// Optional zero fill of unused read lanes: LINT_W2N_ZERO_FILL_EN.
package lint_w2n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam int unsigned MAX_LANES = 8;

  // Lanes touched by a naturally aligned transfer of 2^size lanes; misaligned offset bits are dropped.
  function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned size,
                                                     input int unsigned offset,
                                                     input int unsigned nb_lanes);
    int unsigned log_l;
    int unsigned sz;
    int unsigned n;
    int unsigned base;
    logic [MAX_LANES-1:0] ones;
    log_l = $clog2(nb_lanes);
    sz    = (size > log_l) ? log_l : size;
    n     = 32'd1 << sz;
    base  = offset & ~(n - 32'd1);
    ones  = MAX_LANES'((32'd1 << n) - 32'd1);
    return ones << base;
  endfunction

endpackage

// File: rtl/lint_w2n_lane_trk.sv
// Per-lane tracker: pending-grant and pending-response flags plus the
// captured read data of one narrow lane.
module lint_w2n_lane_trk
  import lint_w2n_pkg::*;
#(
  parameter int unsigned LANE_DW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               launch,
  input  logic               act,
  input  logic               issue,
  input  logic               gnt,
  input  logic               r_valid,
  input  logic [LANE_DW-1:0] rdata,
  output logic               gnt_pend,
  output logic               rsp_pend,
  output logic [LANE_DW-1:0] rdata_q
);

  logic capture;
  logic gnt_pend_d;
  logic rsp_set;

  assign capture = rsp_pend & r_valid;

  always_comb begin
    gnt_pend_d = gnt_pend;
    rsp_set    = 1'b0;
    if (launch) begin
      gnt_pend_d = act & ~gnt;
      rsp_set    = act & gnt;
    end else if (issue) begin
      gnt_pend_d = gnt_pend & ~gnt;
      rsp_set    = gnt_pend & gnt;
    end
  end

  // A lane may complete and be granted again in the same cycle; the new grant wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_pend <= 1'b0;
      rsp_pend <= 1'b0;
      rdata_q  <= '0;
    end else begin
      gnt_pend <= gnt_pend_d;
      rsp_pend <= (rsp_pend & ~r_valid) | rsp_set;
      if (capture) rdata_q <= rdata;
    end
  end

endmodule

// File: rtl/lint_wide_to_narrow.sv
// Splits one wide LINT port into NB_LANES narrow lanes and reassembles the read response.
// Define LINT_W2N_ZERO_FILL_EN to zero inactive lanes and gate read data with r_valid.
module lint_wide_to_narrow
  import lint_w2n_pkg::*;
#(
  parameter int unsigned NB_LANES = 2,
  parameter int unsigned LANE_DW  = 32,
  parameter int unsigned AW       = 32,
  localparam int unsigned LOG_L   = $clog2(NB_LANES),
  localparam int unsigned LB      = $clog2(LANE_DW/8),
  localparam int unsigned SW      = $clog2(LOG_L+1),
  localparam int unsigned BW      = LANE_DW/8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                data_req_i,
  output logic                                data_gnt_o,
  input  logic [AW-1:0]                       data_add_i,
  input  logic                                data_wen_i,
  input  logic [NB_LANES*LANE_DW-1:0]         data_wdata_i,
  input  logic [NB_LANES*BW-1:0]              data_be_i,
  input  logic [SW-1:0]                       data_size_i,
  output logic                                data_r_valid_o,
  output logic [NB_LANES*LANE_DW-1:0]         data_r_rdata_o,
  output logic [NB_LANES-1:0]                 data_req_o,
  input  logic [NB_LANES-1:0]                 data_gnt_i,
  output logic [NB_LANES-1:0][AW-1:0]         data_add_o,
  output logic [NB_LANES-1:0]                 data_wen_o,
  output logic [NB_LANES-1:0][LANE_DW-1:0]    data_wdata_o,
  output logic [NB_LANES-1:0][BW-1:0]         data_be_o,
  input  logic [NB_LANES-1:0]                 data_r_valid_i,
  input  logic [NB_LANES-1:0][LANE_DW-1:0]    data_r_rdata_i,
  output logic [1:0]                          dbg_state
);

  state_e                           state_q;
  state_e                           state_d;
  logic [MAX_LANES-1:0]             mask_full;
  logic [NB_LANES-1:0]              mask;
  logic [NB_LANES-1:0]              g;
  logic [NB_LANES-1:0]              act_q;
  logic [NB_LANES-1:0]              gnt_pend;
  logic [NB_LANES-1:0]              rsp_pend;
  logic [NB_LANES-1:0][LANE_DW-1:0] rdata_q;
  logic                             done;
  logic                             launch_ok;
  logic                             launch;
  logic                             issue;
  logic                             issue_done;
  logic                             unused_add;

  assign mask_full = lane_mask(32'(data_size_i), 32'(data_add_i[LB +: LOG_L]), NB_LANES);
  assign mask      = mask_full[NB_LANES-1:0];
  assign g         = data_gnt_i & mask;

  // Byte offset inside a lane carries no routing information.
  assign unused_add = ^data_add_i[LB-1:0];

  assign issue      = (state_q == ST_ISSUE);
  assign done       = (state_q == ST_RESP) && ((rsp_pend & ~data_r_valid_i) == '0);
  assign launch_ok  = (state_q == ST_IDLE) || done;
  assign launch     = launch_ok && data_req_i;
  assign issue_done = issue && ((gnt_pend & ~data_gnt_i) == '0);

  assign data_r_valid_o = done;
  assign dbg_state      = state_q;

  always_comb begin
    state_d    = state_q;
    data_req_o = '0;
    data_gnt_o = 1'b0;
    if (launch_ok) begin
      data_req_o = mask & {NB_LANES{data_req_i}};
      if (data_req_i) begin
        data_gnt_o = (g == mask);
        state_d    = (g == mask) ? ST_RESP : ST_ISSUE;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (issue) begin
      // Only lanes still waiting for a grant are requested again.
      data_req_o = gnt_pend;
      if (issue_done) begin
        data_gnt_o = 1'b1;
        state_d    = ST_RESP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      if (launch) act_q <= mask;
    end
  end

  for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
    localparam logic [LOG_L-1:0] IDX = LOG_L'(i);
    logic               gnt_pend_l;
    logic               rsp_pend_l;
    logic [LANE_DW-1:0] rdata_q_l;
    logic               sel_live;
    logic [LANE_DW-1:0] lane_rdata;

    assign data_add_o[i]   = {data_add_i[AW-1:LB+LOG_L], IDX, {LB{1'b0}}};
    assign data_wen_o[i]   = data_wen_i;
    assign data_wdata_o[i] = data_wdata_i[i*LANE_DW +: LANE_DW];
    assign data_be_o[i]    = data_be_i[i*BW +: BW];

    lint_w2n_lane_trk #(
      .LANE_DW (LANE_DW)
    ) u_trk (
      .clk      (clk),
      .rst_n    (rst_n),
      .launch   (launch),
      .act      (mask[i]),
      .issue    (issue),
      .gnt      (data_gnt_i[i]),
      .r_valid  (data_r_valid_i[i]),
      .rdata    (data_r_rdata_i[i]),
      .gnt_pend (gnt_pend_l),
      .rsp_pend (rsp_pend_l),
      .rdata_q  (rdata_q_l)
    );

    assign gnt_pend[i] = gnt_pend_l;
    assign rsp_pend[i] = rsp_pend_l;
    assign rdata_q[i]  = rdata_q_l;

    // Active lanes answering now pass through; earlier answers come from the capture.
    assign sel_live   = ~act_q[i] | (rsp_pend[i] & data_r_valid_i[i]);
    assign lane_rdata = sel_live ? data_r_rdata_i[i] : rdata_q[i];

`ifdef LINT_W2N_ZERO_FILL_EN
    assign data_r_rdata_o[i*LANE_DW +: LANE_DW] = (done && act_q[i]) ? lane_rdata : '0;
`else
    assign data_r_rdata_o[i*LANE_DW +: LANE_DW] = lane_rdata;
`endif
  end

endmodule

// File: tb/tb_lint_wide_to_narrow.sv
// Directed bench for lint_wide_to_narrow with four 32-bit lanes.
module tb_lint_wide_to_narrow;

  localparam int unsigned NB_LANES = 4;
  localparam int unsigned LANE_DW  = 32;
  localparam int unsigned AW       = 32;

  logic                      clk;
  logic                      rst_n;
  logic                      data_req_i;
  logic                      data_gnt_o;
  logic [AW-1:0]             data_add_i;
  logic                      data_wen_i;
  logic [127:0]              data_wdata_i;
  logic [15:0]               data_be_i;
  logic [1:0]                data_size_i;
  logic                      data_r_valid_o;
  logic [127:0]              data_r_rdata_o;
  logic [3:0]                data_req_o;
  logic [3:0]                data_gnt_i;
  logic [3:0][31:0]          data_add_o;
  logic [3:0]                data_wen_o;
  logic [3:0][31:0]          data_wdata_o;
  logic [3:0][3:0]           data_be_o;
  logic [3:0]                data_r_valid_i;
  logic [3:0][31:0]          data_r_rdata_i;
  logic [1:0]                dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_rd;

  lint_wide_to_narrow #(
    .NB_LANES (NB_LANES),
    .LANE_DW  (LANE_DW),
    .AW       (AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_size_i    (data_size_i),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_req_o     (data_req_o),
    .data_gnt_i     (data_gnt_i),
    .data_add_o     (data_add_o),
    .data_wen_o     (data_wen_o),
    .data_wdata_o   (data_wdata_o),
    .data_be_o      (data_be_o),
    .data_r_valid_i (data_r_valid_i),
    .data_r_rdata_i (data_r_rdata_i),
    .dbg_state      (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    data_req_i     = 1'b0;
    data_gnt_i     = '0;
    data_r_valid_i = '0;
    data_r_rdata_i = '0;
  endtask

  task automatic drive_req(input logic [31:0] add, input logic wen, input logic [1:0] size,
                           input logic [3:0] gnt);
    data_req_i  = 1'b1;
    data_add_i  = add;
    data_wen_i  = wen;
    data_size_i = size;
    data_gnt_i  = gnt;
  endtask

  task automatic check_read(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 128'd1, 128'd0);
    end else begin
      exp_rd = exp_q.pop_front();
      check(tag, data_r_rdata_o, exp_rd);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    data_add_i   = '0;
    data_wen_i   = 1'b0;
    data_wdata_i = '0;
    data_be_i    = '0;
    data_size_i  = '0;
    clear_inputs();

    // Reset values
    #2;
    check("rst_gnt", 128'(data_gnt_o), 128'd0);
    check("rst_rvalid", 128'(data_r_valid_o), 128'd0);
    check("rst_req", 128'(data_req_o), 128'd0);
    check("rst_rdata", data_r_rdata_o, 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    #1 rst_n = 1'b1;
    next_cycle();

    // Full-width read, all lanes granted at once
    drive_req(32'h100, 1'b1, 2'd2, 4'hF);
    exp_q.push_back({32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000});
    @(negedge clk);
    check("full_req", 128'(data_req_o), 128'hF);
    check("full_gnt", 128'(data_gnt_o), 128'd1);
    check("full_add0", 128'(data_add_o[0]), 128'h100);
    check("full_add3", 128'(data_add_o[3]), 128'h10C);
    check("full_rvalid_c0", 128'(data_r_valid_o), 128'd0);
    next_cycle();
    clear_inputs();
    data_r_valid_i = 4'hF;
    data_r_rdata_i = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    @(negedge clk);
    check("full_rvalid", 128'(data_r_valid_o), 128'd1);
    check("full_gnt_c1", 128'(data_gnt_o), 128'd0);
    check_read("full_rdata");
    next_cycle();
    clear_inputs();

    // Single-lane write on lane 2, lane 0 sends a spurious response at completion
    data_wdata_i = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    data_be_i    = 16'h5A3C;
    drive_req(32'h108, 1'b0, 2'd0, 4'b0100);
    @(negedge clk);
    check("wr_req", 128'(data_req_o), 128'b0100);
    check("wr_gnt", 128'(data_gnt_o), 128'd1);
    check("wr_add2", 128'(data_add_o[2]), 128'h108);
    check("wr_be2", 128'(data_be_o[2]), 128'hA);
    check("wr_wdata2", 128'(data_wdata_o[2]), 128'h3333_3333);
    check("wr_wen2", 128'(data_wen_o[2]), 128'd0);
    next_cycle();
    clear_inputs();
    data_r_valid_i = 4'b0001;
    @(negedge clk);
    check("wr_spurious", 128'(data_r_valid_o), 128'd0);
    next_cycle();
    data_r_valid_i = 4'b0101;
    @(negedge clk);
    check("wr_rvalid", 128'(data_r_valid_o), 128'd1);
    next_cycle();
    clear_inputs();

    // Split grant: lane 0 then lane 1; lane 0 answers while lane 1 is still ungranted
    drive_req(32'h100, 1'b1, 2'd1, 4'b0001);
    exp_q.push_back({64'h0, 32'hD1D1_0001, 32'hD0D0_0000});
    @(negedge clk);
    check("split_req_c0", 128'(data_req_o), 128'b0011);
    check("split_gnt_c0", 128'(data_gnt_o), 128'd0);
    next_cycle();
    data_gnt_i        = 4'b0010;
    data_r_valid_i    = 4'b0001;
    data_r_rdata_i[0] = 32'hD0D0_0000;
    @(negedge clk);
    check("split_state", 128'(dbg_state), 128'd1);
    check("split_req_c1", 128'(data_req_o), 128'b0010);
    check("split_gnt_c1", 128'(data_gnt_o), 128'd1);
    check("split_rvalid_c1", 128'(data_r_valid_o), 128'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("split_rvalid_c2", 128'(data_r_valid_o), 128'd0);
    next_cycle();
    data_r_valid_i    = 4'b0010;
    data_r_rdata_i[1] = 32'hD1D1_0001;
    data_r_rdata_i[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("split_rvalid_c3", 128'(data_r_valid_o), 128'd1);
    exp_rd = exp_q.pop_front();
    check("split_rdata", 128'(data_r_rdata_o[63:0]), 128'(exp_rd[63:0]));
    next_cycle();
    clear_inputs();

    // Staggered responses: lane 1 in cycle 2, lane 0 in cycle 4
    drive_req(32'h100, 1'b1, 2'd1, 4'b0011);
    @(negedge clk);
    check("stag_gnt", 128'(data_gnt_o), 128'd1);
    next_cycle();
    clear_inputs();
    next_cycle();
    data_r_valid_i    = 4'b0010;
    data_r_rdata_i[1] = 32'hE1E1_0001;
    @(negedge clk);
    check("stag_rvalid_c2", 128'(data_r_valid_o), 128'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("stag_rvalid_c3", 128'(data_r_valid_o), 128'd0);
`ifdef LINT_W2N_ZERO_FILL_EN
    check("stag_zero_fill", data_r_rdata_o, 128'd0);
`endif
    next_cycle();
    data_r_valid_i    = 4'b0001;
    data_r_rdata_i[0] = 32'hE0E0_0000;
    data_r_rdata_i[1] = 32'h5555_5555;
    @(negedge clk);
    check("stag_rvalid_c4", 128'(data_r_valid_o), 128'd1);
    check("stag_rdata", 128'(data_r_rdata_o[63:0]), 128'hE1E1_0001_E0E0_0000);
    next_cycle();
    clear_inputs();

    // Back-to-back: second request granted in the completion cycle of the first
    drive_req(32'h200, 1'b1, 2'd2, 4'hF);
    exp_q.push_back({32'hB3, 32'hB2, 32'hB1, 32'hB0});
    exp_q.push_back({32'hC3, 32'hC2, 32'hC1, 32'hC0});
    @(negedge clk);
    check("b2b_gnt0", 128'(data_gnt_o), 128'd1);
    next_cycle();
    drive_req(32'h300, 1'b1, 2'd2, 4'hF);
    data_r_valid_i = 4'hF;
    data_r_rdata_i = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    @(negedge clk);
    check("b2b_rvalid0", 128'(data_r_valid_o), 128'd1);
    check("b2b_gnt1", 128'(data_gnt_o), 128'd1);
    check("b2b_req1", 128'(data_req_o), 128'hF);
    check("b2b_add1", 128'(data_add_o[0]), 128'h300);
    check_read("b2b_rdata0");
    next_cycle();
    clear_inputs();
    data_r_valid_i = 4'hF;
    data_r_rdata_i = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    @(negedge clk);
    check("b2b_rvalid1", 128'(data_r_valid_o), 128'd1);
    check_read("b2b_rdata1");
    next_cycle();
    clear_inputs();

    // Misaligned offset ignored: size 1 at 0x104 covers lanes 0 and 1
    drive_req(32'h104, 1'b1, 2'd1, 4'b0000);
    @(negedge clk);
    check("mis_req", 128'(data_req_o), 128'b0011);
    next_cycle();
    data_gnt_i = 4'b0011;
    @(negedge clk);
    check("mis_gnt", 128'(data_gnt_o), 128'd1);
    next_cycle();
    clear_inputs();
    data_r_valid_i = 4'b0011;
    @(negedge clk);
    check("mis_rvalid", 128'(data_r_valid_o), 128'd1);
    next_cycle();
    clear_inputs();

    // Oversized size clamps to all lanes; reset while in ISSUE
    drive_req(32'h100, 1'b1, 2'd3, 4'b0101);
    @(negedge clk);
    check("clamp_req", 128'(data_req_o), 128'hF);
    check("clamp_add3", 128'(data_add_o[3]), 128'h10C);
    next_cycle();
    data_gnt_i = 4'b0000;
    @(negedge clk);
    check("clamp_state", 128'(dbg_state), 128'd1);
    check("clamp_reissue", 128'(data_req_o), 128'b1010);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("mrst_req", 128'(data_req_o), 128'd0);
    check("mrst_gnt", 128'(data_gnt_o), 128'd0);
    check("mrst_state", 128'(dbg_state), 128'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    data_r_valid_i = 4'hF;
    data_r_rdata_i = {4{32'hFFFF_FFFF}};
    @(negedge clk);
    check("stray_rvalid", 128'(data_r_valid_o), 128'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("stray_state", 128'(dbg_state), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lint_wide_to_narrow.md
# lint_wide_to_narrow

Parametrised splitter from one wide LINT initiator port to NB_LANES narrow LINT target lanes, sitting between a wide bus adapter and the interleaved 32-bit TCDM/L2 banks. Supports naturally aligned transfers of 1 to NB_LANES lanes, independent per-lane grant and response tracking, and reassembly of the wide read response. One transaction in flight; the next may be issued in the cycle the previous one completes.

## Interface
- NB_LANES, 2: narrow lane count; power of two, 2..8
- LANE_DW, 32: narrow lane data width in bits
- AW, 32: address width
- Derived: LOG_L = $clog2(NB_LANES), LB = $clog2(LANE_DW/8), SW = $clog2(LOG_L+1)

Reset is rst_n, asynchronous, active-low; clock is clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- data_req_i  in  1  wide request
- data_gnt_o  out  1  wide grant
- data_add_i  in  AW  byte address
- data_wen_i  in  1  1 = read, 0 = write
- data_wdata_i  in  NB_LANES*LANE_DW  write data
- data_be_i  in  NB_LANES*LANE_DW/8  byte enables
- data_size_i  in  SW  transfer spans 2^size lanes
- data_r_valid_o  out  1  wide response valid
- data_r_rdata_o  out  NB_LANES*LANE_DW  wide read data
- data_req_o  out  [NB_LANES]  lane requests
- data_gnt_i  in  [NB_LANES]  lane grants
- data_add_o  out  [NB_LANES][AW]  lane addresses
- data_wen_o  out  [NB_LANES]  lane wen
- data_wdata_o  out  [NB_LANES][LANE_DW]  lane write data
- data_be_o  out  [NB_LANES][LANE_DW/8]  lane byte enables
- data_r_valid_i  in  [NB_LANES]  lane response valid
- data_r_rdata_i  in  [NB_LANES][LANE_DW]  lane read data

## Operation
- Active mask: n = 2^size (size > LOG_L clamps to LOG_L); base = add[LB+:LOG_L] & ~(n-1); mask = ((1<<n)-1) << base. Misaligned offset bits are ignored.
- Lane i: add_o = {add[AW-1:LB+LOG_L], i[LOG_L-1:0], LB'b0}; wdata, be, wen are pure slices/copies of the inputs.
- Registers: gnt_pend[NB_LANES], rsp_pend[NB_LANES], act_q[NB_LANES], rdata_q[NB_LANES][LANE_DW], CS.
- States: IDLE, ISSUE, RESP.
- Launch (IDLE, or RESP in its completion cycle): req_o = mask & {req_i}; g = gnt_i & mask. g == mask: gnt_o = 1, go RESP. Otherwise go ISSUE with gnt_pend = mask & ~g. In both cases rsp_pend |= g and act_q = mask. With req_i low: go IDLE.
- ISSUE: req_o = gnt_pend only; lanes already granted are never re-requested. Granted lanes clear from gnt_pend and set rsp_pend. When gnt_pend & ~gnt_i == 0: gnt_o = 1, go RESP.
- Response: r_valid_i on a lane with rsp_pend set captures rdata into rdata_q and clears rsp_pend. Responses may arrive while in ISSUE.
- Completion: in RESP, when rsp_pend & ~r_valid_i == 0, r_valid_o = 1. Each lane's data comes live if its r_valid_i is high that cycle, else from rdata_q. This cycle is a launch cycle.
- Spurious r_valid_i on a lane without rsp_pend is ignored.
- Initiator holds req/add/size/wdata stable until gnt_o. The block does not latch request fields.

## Timing
- Reset values: data_gnt_o = 0, data_r_valid_o = 0, data_req_o = 0, data_r_rdata_o = 0 (masks clear), CS = IDLE. Reset mid-transaction drops it; late lane responses are ignored.
- Grant latency: same cycle as the last lane grant (combinational gnt_i to gnt_o).
- Response: r_valid_o is never earlier than the cycle after the wide grant, and is combinational from the final lane r_valid_i.
- Back-to-back: new launch in the completion cycle, so zero bubble.
- gnt_o and r_valid_o of the same transaction are never in the same cycle.

## Configuration
- LINT_W2N_ZERO_FILL_EN defined: lanes outside act_q read as zero in data_r_rdata_o, and data_r_rdata_o is zero whenever r_valid_o = 0.
- LINT_W2N_ZERO_FILL_EN undefined: inactive lanes carry live data_r_rdata_i (don't-care), and there is no output gating.

## Structure
- Package lint_w2n_pkg holds the state enum state_e and the function lane_mask(size, offset, NB_LANES).
- Sub-module lint_w2n_lane_trk, instantiated per lane, holds the gnt_pend/rsp_pend bit and rdata_q capture for one lane. The top-level holds the FSM and reassembly.

## Test plan
- NB_LANES=4, size=2 read at 0x100, all gnt_i=4'hF -> gnt_o in cycle 0; r_valid_i=4'hF in cycle 1 -> r_valid_o, rdata = lane data concatenated.
- size=0 write at 0x108 -> only req_o[2] high, add_o[2]=0x108, be_o[2] = be_i[11:8]; other lanes idle.
- size=1 at 0x100, gnt_i=4'b0001 then 4'b0010 a cycle later -> lane 0 not re-requested, gnt_o in cycle 1.
- Staggered responses: lane 1 rvalid in cycle 2, lane 0 rvalid in cycle 4 -> r_valid_o only in cycle 4, lane 1 data from capture.
- Back-to-back: new req_i present at completion with full grant -> new gnt_o in the same cycle as r_valid_o.
- rst_n pulsed in ISSUE -> all outputs 0, IDLE; a later stray r_valid_i causes no r_valid_o. Check with the macro on and off.
